// File: rtl/pmod_frame_display.sv
// rtl/pmod_frame_display.sv - PMOD serial frame receiver with double-dabble BCD seven-segment driver
module pmod_frame_display #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 2,
    parameter int PARITY_EN  = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Ser_Clk,
    input  logic                    i_Ser_Data,
    input  logic                    i_Ser_Frame,
    output logic [7*NUM_DIGITS-1:0] o_Segment,
    output logic                    o_Valid,
    output logic [1:0]              o_Err,
    output logic                    o_Busy
);

    function automatic int calc_bcd_digits(input int w);
        int v;
        int d;
        v = (1 << w) - 1;
        d = 1;
        while (v >= 10) begin
            v = v / 10;
            d++;
        end
        return d;
    endfunction

    localparam int FRAME_W    = DATA_W + PARITY_EN;
    localparam int CNT_W      = $clog2(FRAME_W + 2);
    localparam int DD_W       = $clog2(DATA_W);
    localparam int BCD_DIGITS = calc_bcd_digits(DATA_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [DD_W-1:0]  DD_LAST  = DD_W'(DATA_W - 1);
    localparam logic [6:0]       SEG_DASH = 7'b0111111;
    localparam logic [7*NUM_DIGITS-1:0] SEG_ZEROS = {NUM_DIGITS{7'b1000000}};

    typedef enum logic [1:0] {IDLE, RECV, CONV, LOAD} state_t;

    state_t state, state_next;

    logic clk_s1, clk_s2, clk_h;
    logic data_s1, data_s2, data_h;
    logic frame_s1, frame_s2, frame_h;
    logic ser_rise, frame_rise, frame_fall;

    logic [FRAME_W-1:0] sr, sr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [DATA_W-1:0]  payload, pay_sh;
    logic               len_bad, parity_bad;
    logic [BCD_W-1:0]   bcd;
    logic [DD_W-1:0]    dd_cnt;
    logic               ovr;
    logic [4*NUM_DIGITS-1:0] bcd_ext;
    logic [7*NUM_DIGITS-1:0] seg_load;
    logic               in_range;

    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic bit_in);
        logic [BCD_W-1:0] a;
        a = b;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (a[4*k +: 4] >= 4'd5)
                a[4*k +: 4] = a[4*k +: 4] + 4'd3;
        end
        return {a[BCD_W-2:0], bit_in};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Frame history resets high so a frame already active at reset release never looks like a new start.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_h    <= 1'b0;
            data_s1  <= 1'b0;
            data_s2  <= 1'b0;
            data_h   <= 1'b0;
            frame_s1 <= 1'b1;
            frame_s2 <= 1'b1;
            frame_h  <= 1'b1;
        end else begin
            clk_s1   <= i_Ser_Clk;
            clk_s2   <= clk_s1;
            clk_h    <= clk_s2;
            data_s1  <= i_Ser_Data;
            data_s2  <= data_s1;
            data_h   <= data_s2;
            frame_s1 <= i_Ser_Frame;
            frame_s2 <= frame_s1;
            frame_h  <= frame_s2;
        end
    end

    assign ser_rise   = clk_s2 & ~clk_h;
    assign frame_rise = frame_s2 & ~frame_h;
    assign frame_fall = ~frame_s2 & frame_h;

    // A bit arriving with the frame fall is folded in before the length and parity checks.
    always_comb begin
        sr_next  = sr;
        cnt_next = cnt;
        if (ser_rise) begin
            sr_next = {sr[FRAME_W-2:0], data_h};
            if (cnt != CNT_SAT)
                cnt_next = cnt + CNT_W'(1);
        end
        payload = '0;
        for (int i = 0; i < DATA_W; i++)
            payload[i] = (MSB_FIRST != 0) ? sr_next[PARITY_EN + i] : sr_next[FRAME_W - 1 - i];
        len_bad    = (cnt_next != CNT_FULL);
        parity_bad = (PARITY_EN != 0) && (^sr_next);
    end

    always_comb begin
        bcd_ext = '0;
        for (int i = 0; i < 4*NUM_DIGITS && i < BCD_W; i++)
            bcd_ext[i] = bcd[i];
        in_range = ((bcd >> (4*NUM_DIGITS)) == '0);
        seg_load = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            seg_load[7*k +: 7] = in_range ? seg_of(bcd_ext[4*k +: 4]) : SEG_DASH;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (frame_rise) state_next = RECV;
            RECV: if (frame_fall) state_next = (len_bad || parity_bad) ? IDLE : CONV;
            CONV: if (dd_cnt == DD_LAST) state_next = LOAD;
            LOAD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sr        <= '0;
            cnt       <= '0;
            pay_sh    <= '0;
            bcd       <= '0;
            dd_cnt    <= '0;
            ovr       <= 1'b0;
            o_Segment <= SEG_ZEROS;
            o_Valid   <= 1'b0;
            o_Err     <= 2'b00;
        end else begin
            o_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        sr  <= '0;
                        cnt <= '0;
                    end
                end
                RECV: begin
                    sr  <= sr_next;
                    cnt <= cnt_next;
                    if (frame_fall) begin
                        if (len_bad)
                            o_Err <= 2'b01;
                        else if (parity_bad)
                            o_Err <= 2'b10;
                        else begin
                            pay_sh <= payload;
                            bcd    <= '0;
                            dd_cnt <= '0;
                            ovr    <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    bcd    <= dd_step(bcd, pay_sh[DATA_W-1]);
                    pay_sh <= {pay_sh[DATA_W-2:0], 1'b0};
                    dd_cnt <= dd_cnt + DD_W'(1);
                    if (frame_rise) begin
                        o_Err <= 2'b11;
                        ovr   <= 1'b1;
                    end
                end
                LOAD: begin
                    o_Segment <= seg_load;
                    o_Valid   <= 1'b1;
                    // An overrun seen during conversion must survive the clear on load.
                    o_Err     <= (ovr || frame_rise) ? 2'b11 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    assign o_Busy = (state == RECV) || (state == CONV);

endmodule

// File: tb/tb_pmod_frame_display.sv
// tb/tb_pmod_frame_display.sv - randomized self-checking bench for pmod_frame_display
module tb_pmod_frame_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_clk = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_frame = 1'b0;
    logic [13:0] segment;
    logic        valid;
    logic [1:0]  err;
    logic        busy;

    pmod_frame_display dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Ser_Clk   (ser_clk),
        .i_Ser_Data  (ser_data),
        .i_Ser_Frame (ser_frame),
        .o_Segment   (segment),
        .o_Valid     (valid),
        .o_Err       (err),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int vcount   = 0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic [13:0] exp_disp;
    logic [1:0]  exp_err;
    bit          fbits[$];

    always @(negedge clk) if (valid) vcount++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [13:0] seg_for(input int v);
        if (v > 99)
            return {7'b0111111, 7'b0111111};
        return {pat[v / 10], pat[v % 10]};
    endfunction

    task automatic build(input int v, input int mode, input int extra);
        int ones;
        fbits.delete();
        ones = 0;
        for (int i = 7; i >= 0; i--) begin
            fbits.push_back(v[i]);
            ones += v[i];
        end
        fbits.push_back(ones % 2 == 1);
        if (mode == 1) fbits[8] = ~fbits[8];
        if (mode == 2) for (int i = 0; i < extra; i++) void'(fbits.pop_front());
        if (mode == 3) for (int i = 0; i < extra; i++) fbits.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic send_bit(input bit b);
        ser_data = b;
        repeat (4) @(negedge clk);
        ser_clk = 1'b1;
        repeat (4) @(negedge clk);
        ser_clk = 1'b0;
    endtask

    task automatic send_frame(input string tag, input bit ovr);
        int  v, ones, vpos, vpulses, n, vbefore;
        bit  good;
        n = fbits.size();
        good = 1'b0;
        if (n != 9)
            exp_err = 2'b01;
        else begin
            v = 0;
            ones = 0;
            for (int i = 0; i < 9; i++) ones += int'(fbits[i]);
            for (int i = 0; i < 8; i++) v = v * 2 + int'(fbits[i]);
            if (ones % 2 == 1)
                exp_err = 2'b10;
            else begin
                good = 1'b1;
                exp_err = ovr ? 2'b11 : 2'b00;
                exp_disp = seg_for(v);
            end
        end
        @(negedge clk);
        ser_frame = 1'b1;
        repeat (4) @(negedge clk);
        foreach (fbits[i]) send_bit(fbits[i]);
        repeat (4) @(negedge clk);
        ser_frame = 1'b0;
        vpos = -1;
        vpulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                vpulses++;
                if (vpos < 0) vpos = k;
            end
            if (k == 5) check({tag, ".busy_conv"}, 32'(busy), 32'(good));
            if (ovr && k == 1) ser_frame = 1'b1;
        end
        check({tag, ".valid_pos"}, vpos, good ? 11 : -1);
        check({tag, ".valid_cnt"}, vpulses, 32'(good));
        check({tag, ".seg"}, 32'(segment), 32'(exp_disp));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        if (ovr) begin
            vbefore = vcount;
            for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
            repeat (4) @(negedge clk);
            ser_frame = 1'b0;
            repeat (20) @(negedge clk);
            check({tag, ".ovr_novalid"}, vcount, vbefore);
            check({tag, ".ovr_err"}, 32'(err), 32'(2'b11));
            check({tag, ".ovr_seg"}, 32'(segment), 32'(exp_disp));
        end
        check({tag, ".busy_idle"}, 32'(busy), 32'(1'b0));
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int vbefore;
        exp_disp = {pat[0], pat[0]};
        exp_err  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.seg", 32'(segment), 32'(exp_disp));
        check("rst.valid", 32'(valid), 0);
        check("rst.err", 32'(err), 0);
        check("rst.busy", 32'(busy), 0);
        repeat (4) @(negedge clk);

        build(42, 0, 0);  send_frame("good42", 1'b0);
        build(42, 1, 0);  send_frame("par42", 1'b0);
        build(42, 2, 1);  send_frame("short", 1'b0);
        build(5, 0, 0);   send_frame("good05", 1'b0);
        build(200, 0, 0); send_frame("range200", 1'b0);
        build(37, 0, 0);  send_frame("ovr37", 1'b1);

        // reset in the middle of a frame, frame held high across release
        @(negedge clk);
        ser_frame = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(posedge clk); #1;
        check("mid.busy", 32'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_disp = {pat[0], pat[0]};
        exp_err = 2'b00;
        vbefore = vcount;
        #1;
        check("mid.rst_seg", 32'(segment), 32'(exp_disp));
        check("mid.rst_err", 32'(err), 0);
        check("mid.rst_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        repeat (4) @(negedge clk);
        ser_frame = 1'b0;
        repeat (20) @(negedge clk);
        check("mid.novalid", vcount, vbefore);
        check("mid.seg", 32'(segment), 32'(exp_disp));
        check("mid.err", 32'(err), 0);
        build(99, 0, 0);  send_frame("good99", 1'b0);

        for (int r = 0; r < 20; r++) begin
            int mode;
            mode = (r % 3 == 0) ? int'($urandom_range(0, 3)) : 0;
            build(int'($urandom_range(0, 255)), mode, int'($urandom_range(1, 2)));
            send_frame($sformatf("rnd%0d", r), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
